wasm_perf_monitor: RTL

Synthesizable, parametrised run monitor for the WASM core: measures the cycles from a run start to completion, counts up to N_EVT per-cycle event channels, and enforces a programmable watchdog timeout. It sits beside the WASM top-level core and taps its finish, error and status strobes (e.g. stack_full). It replaces testbench-only cycle counting with hardware results that both benches and on-chip debug logic can read.

---
 rtl/wasm_perf_pkg.sv | 17 +
 rtl/wasm_sat_counter.sv | 35 +++
 rtl/wasm_perf_monitor.sv | 120 ++++++++++++
 3 files changed

// File: rtl/wasm_perf_pkg.sv
// rtl/wasm_perf_pkg.sv - state and status encodings shared by the WASM run monitor
package wasm_perf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ST_NONE    = 2'b00,
    ST_FINISH  = 2'b01,
    ST_ERROR   = 2'b10,
    ST_TIMEOUT = 2'b11
  } status_e;

endpackage

// File: rtl/wasm_sat_counter.sv
// rtl/wasm_sat_counter.sv - saturating up-counter with synchronous clear
module wasm_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Clear wins over increment; the count sticks at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/wasm_perf_monitor.sv
// rtl/wasm_perf_monitor.sv - run-length, event-count and watchdog monitor for the WASM core
module wasm_perf_monitor
  import wasm_perf_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int N_EVT = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_start,
  input  logic                   i_finish,
  input  logic                   i_error,
  input  logic [N_EVT-1:0]       i_evt,
  input  logic [CNT_W-1:0]       i_timeout_limit,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [1:0]             o_status,
  output logic [CNT_W-1:0]       o_cycles,
  output logic [N_EVT*CNT_W-1:0] o_evt_cnt,
  output logic                   o_timeout
);

  state_e           state_q, state_d;
  status_e          status_q, status_d;
  logic [CNT_W-1:0] limit_q, limit_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;

  logic             cnt_clr;
  logic             cyc_inc;
  logic [N_EVT-1:0] evt_inc;
  logic [CNT_W-1:0] cycles;

  // Termination priority in RUN: error, then finish, then watchdog.
  always_comb begin
    state_d   = state_q;
    status_d  = status_q;
    limit_d   = limit_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    cnt_clr   = 1'b0;
    cyc_inc   = 1'b0;
    evt_inc   = '0;
    case (state_q)
      IDLE, DONE: begin
        if (i_start) begin
          state_d  = RUN;
          status_d = ST_NONE;
          limit_d  = i_timeout_limit;
          cnt_clr  = 1'b1;
        end
      end
      RUN: begin
        evt_inc = i_evt;
        if (i_error) begin
          state_d  = DONE;
          status_d = ST_ERROR;
          done_d   = 1'b1;
        end else if (i_finish) begin
          state_d  = DONE;
          status_d = ST_FINISH;
          done_d   = 1'b1;
        end else if ((limit_q != '0) && (cycles == limit_q)) begin
          state_d   = DONE;
          status_d  = ST_TIMEOUT;
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end else begin
          cyc_inc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      status_q  <= ST_NONE;
      limit_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      status_q  <= status_d;
      limit_q   <= limit_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  wasm_sat_counter #(.W(CNT_W)) u_cyc_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (cyc_inc),
    .q     (cycles)
  );

  for (genvar k = 0; k < N_EVT; k++) begin : g_evt
    wasm_sat_counter #(.W(CNT_W)) u_evt_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .inc   (evt_inc[k]),
      .q     (o_evt_cnt[k*CNT_W +: CNT_W])
    );
  end

  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_timeout = timeout_q;
  assign o_status  = status_q;
  assign o_cycles  = cycles;

endmodule
